// File: rtl/core_types_pkg.sv
// core_types_pkg: shared pipeline types for the execute stage and its M-extension unit
package core_types_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;
   typedef enum logic [3:0] {
      MD_NONE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } md_op_t;
   typedef logic [1:0] md_state_t;
   localparam md_state_t MD_IDLE = 2'd0;
   localparam md_state_t MD_BUSY = 2'd1;
   localparam md_state_t MD_DONE = 2'd2;
   typedef struct packed {
      logic       we;
      logic [4:0] rd;
   } rf_ctrl_t;
   typedef struct packed {
      logic       is_jal;
      logic       is_jalr;
      logic       is_branch;
      logic [2:0] branch_fn;
   } ctrl_transfer_t;
   function automatic logic md_a_signed(input md_op_t op);
      return op inside {MULH, MULHSU, DIV, REM};
   endfunction
   function automatic logic md_b_signed(input md_op_t op);
      return op inside {MULH, DIV, REM};
   endfunction
   function automatic logic md_is_div(input md_op_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction
   function automatic logic md_is_rem(input md_op_t op);
      return op inside {REM, REMU};
   endfunction
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative M-extension unit, shift-add multiply and restoring divide at one bit per cycle
module muldiv_seq
   import core_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic            hold,
   input  md_op_t          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   md_state_t         state_q, state_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              sa, sb, div_op, div0, ovf;
   logic [XLEN-1:0]   abs_a, abs_b, q_res, r_res;
   logic [XLEN:0]     add_sum, rem_sh, diff;
   logic [2*XLEN-1:0] step, prod;
   always_comb begin
      sa = md_a_signed(op) & a[XLEN-1];
      sb = md_b_signed(op) & b[XLEN-1];
      abs_a = sa ? -a : a;
      abs_b = sb ? -b : b;
      div_op = md_is_div(op);
      div0 = div_op & (b == '0);
      ovf = div_op & md_b_signed(op) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
      // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
      rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff = rem_sh - {1'b0, dvs_q};
      step = !div_op ? {add_sum, acc_q[XLEN-1:1]} :
             diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                          {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      prod = neg_q ? -acc_q : acc_q;
      q_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      r_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      result = op == MUL ? prod[XLEN-1:0] : !div_op ? prod[2*XLEN-1:XLEN] :
               md_is_rem(op) ? r_res : q_res;
      state_d = state_q;
      acc_d = acc_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      neg_d = neg_q;
      if (kill)
         state_d = MD_IDLE;
      else if (state_q == MD_IDLE && start) begin
         // corner cases preload the answer so the result path needs no special muxing
         state_d = (div0 | ovf) ? MD_DONE : MD_BUSY;
         acc_d = div0 ? {a, {XLEN{1'b1}}} : ovf ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, abs_a};
         dvs_d = abs_b;
         neg_d = !(div0 | ovf) & (md_is_rem(op) ? sa : sa ^ sb);
         cnt_d = CW'(XLEN-1);
      end else if (state_q == MD_BUSY) begin
         acc_d = step;
         cnt_d = cnt_q - 1'b1;
         state_d = cnt_q == '0 ? MD_DONE : MD_BUSY;
      end else if (state_q == MD_DONE && !hold)
         state_d = MD_IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= MD_IDLE;
         acc_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         neg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         neg_q <= neg_d;
      end
   assign busy = state_q == MD_BUSY;
   assign done = state_q == MD_DONE;
endmodule

// File: rtl/x_stage_md.sv
// x_stage_md: execute stage with ALU, branch/jalr resolution and an iterative M-extension unit
module x_stage_md
   import core_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  alu_op_t         alu_op_nxt,
   input  md_op_t          md_op_nxt,
   input  rf_ctrl_t        rf_ctrl_pkt_in,
   output rf_ctrl_t        rf_ctrl_pkt_out,
   input  ctrl_transfer_t  ctrl_transfer_pkt_in,
   input  logic [XLEN-1:0] op1_nxt,
   input  logic [XLEN-1:0] op2_nxt,
   input  logic [XLEN-1:0] pc_nxt,
   input  logic [XLEN-1:0] branch_tgt_in,
   output logic [XLEN-1:0] data_out,
   output logic [XLEN-1:0] branch_tgt,
   output logic            branch_vld,
   output logic [XLEN-1:0] jalr_tgt,
   output logic            jalr_vld,
   input  logic            vld_in,
   output logic            vld,
   input  logic            stall_in,
   output logic            stall,
   input  logic            squash_in,
   output logic            squash,
   output logic            md_busy
);
   localparam int SW = $clog2(XLEN);
   logic            vld_q;
   logic [XLEN-1:0] op1_q, op2_q, pc_q, btgt_q;
   alu_op_t         alu_op_q;
   md_op_t          md_op_q;
   rf_ctrl_t        rf_q;
   ctrl_transfer_t  ct_q;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_res, md_res;
   logic            eq, lt, ltu, cmp, taken, mop, md_done, gen_stall;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld_q <= 1'b0;
         op1_q <= '0;
         op2_q <= '0;
         pc_q <= '0;
         btgt_q <= '0;
         alu_op_q <= ALU_ADD;
         md_op_q <= MD_NONE;
         rf_q <= '0;
         ct_q <= '0;
      end else if (!stall) begin
         vld_q <= vld_in;
         op1_q <= op1_nxt;
         op2_q <= op2_nxt;
         pc_q <= pc_nxt;
         btgt_q <= branch_tgt_in;
         alu_op_q <= alu_op_nxt;
         md_op_q <= md_op_nxt;
         rf_q <= rf_ctrl_pkt_in;
         ct_q <= ctrl_transfer_pkt_in;
      end
   always_comb begin
      shamt = op2_q[SW-1:0];
      case (alu_op_q)
         ALU_SUB:  alu_res = op1_q - op2_q;
         ALU_SLL:  alu_res = op1_q << shamt;
         ALU_SLT:  alu_res = XLEN'($signed(op1_q) < $signed(op2_q));
         ALU_SLTU: alu_res = XLEN'(op1_q < op2_q);
         ALU_XOR:  alu_res = op1_q ^ op2_q;
         ALU_SRL:  alu_res = op1_q >> shamt;
         ALU_SRA:  alu_res = XLEN'($signed(op1_q) >>> shamt);
         ALU_OR:   alu_res = op1_q | op2_q;
         ALU_AND:  alu_res = op1_q & op2_q;
         default:  alu_res = op1_q + op2_q;
      endcase
      eq = op1_q == op2_q;
      lt = $signed(op1_q) < $signed(op2_q);
      ltu = op1_q < op2_q;
      // fn[2:1]: 00 eq, 10 lt, 11 ltu, 01 never; fn[0] inverts
      cmp = ct_q.branch_fn[2:1] == 2'b00 ? eq : ct_q.branch_fn[2:1] == 2'b10 ? lt :
            ct_q.branch_fn[2:1] == 2'b11 ? ltu : 1'b0;
      taken = cmp ^ ct_q.branch_fn[0];
   end
   assign mop = vld_q & (md_op_q != MD_NONE);
   muldiv_seq #(.XLEN(XLEN)) u_md (
      .clk(clk), .rst(rst), .start(mop), .kill(squash_in), .hold(stall_in), .op(md_op_q),
      .a(op1_q), .b(op2_q), .busy(md_busy), .done(md_done), .result(md_res)
   );
   assign gen_stall = mop & !md_done & !squash_in;
   assign stall = stall_in | gen_stall;
   assign vld = vld_q & !gen_stall & !squash_in;
   assign data_out = md_op_q != MD_NONE ? md_res :
                     (ct_q.is_jal | ct_q.is_jalr) ? pc_q + XLEN'(4) : alu_res;
   assign jalr_tgt = {alu_res[XLEN-1:1], 1'b0};
   assign jalr_vld = vld & ct_q.is_jalr;
   assign branch_vld = vld & ct_q.is_branch & taken;
   assign branch_tgt = btgt_q;
   assign squash = squash_in | jalr_vld | branch_vld;
   assign rf_ctrl_pkt_out = rf_q;
endmodule

// File: tb/tb_x_stage_md.sv
// tb_x_stage_md: scoreboard bench driving XLEN=32 and XLEN=16 instances of the execute stage
module tb_x_stage_md;
   import core_types_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   alu_op_t alu_op = ALU_ADD;
   md_op_t md_op = MD_NONE;
   rf_ctrl_t rf_in = '0;
   ctrl_transfer_t ct_in = '0;
   logic [31:0] op1 = '0, op2 = '0, pc = '0, btgt = '0;
   logic vld_in = 1'b0, stall_in = 1'b0, squash_in = 1'b0;
   rf_ctrl_t rf32, rf16;
   logic [31:0] d32, bt32, jt32;
   logic [15:0] d16, bt16, jt16;
   logic bv32, jv32, v32, s32, sq32, mb32, bv16, jv16, v16, s16, sq16, mb16;
   bit use16 = 1'b0;
   logic [31:0] dout;
   logic vld_o, stall_o, busy_o;
   int n_checks = 0, n_fail = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_v;

   x_stage_md #(.XLEN(32)) u32 (
      .clk(clk), .rst(rst), .alu_op_nxt(alu_op), .md_op_nxt(md_op), .rf_ctrl_pkt_in(rf_in),
      .rf_ctrl_pkt_out(rf32), .ctrl_transfer_pkt_in(ct_in), .op1_nxt(op1), .op2_nxt(op2),
      .pc_nxt(pc), .branch_tgt_in(btgt), .data_out(d32), .branch_tgt(bt32), .branch_vld(bv32),
      .jalr_tgt(jt32), .jalr_vld(jv32), .vld_in(vld_in), .vld(v32), .stall_in(stall_in),
      .stall(s32), .squash_in(squash_in), .squash(sq32), .md_busy(mb32)
   );
   x_stage_md #(.XLEN(16)) u16 (
      .clk(clk), .rst(rst), .alu_op_nxt(alu_op), .md_op_nxt(md_op), .rf_ctrl_pkt_in(rf_in),
      .rf_ctrl_pkt_out(rf16), .ctrl_transfer_pkt_in(ct_in), .op1_nxt(op1[15:0]), .op2_nxt(op2[15:0]),
      .pc_nxt(pc[15:0]), .branch_tgt_in(btgt[15:0]), .data_out(d16), .branch_tgt(bt16), .branch_vld(bv16),
      .jalr_tgt(jt16), .jalr_vld(jv16), .vld_in(vld_in), .vld(v16), .stall_in(stall_in),
      .stall(s16), .squash_in(squash_in), .squash(sq16), .md_busy(mb16)
   );
   assign dout = use16 ? {16'h0, d16} : d32;
   assign vld_o = use16 ? v16 : v32;
   assign stall_o = use16 ? s16 : s32;
   assign busy_o = use16 ? mb16 : mb32;

   md_op_t t32_op [13] = '{MULH, DIV, REM, MUL, MULHSU, MULHU, DIVU, REM, DIV, REM, DIVU, REMU, DIV};
   logic [31:0] t32_a [13] = '{32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd100, 32'hFFFFFFFF, 32'd7};
   logic [31:0] t32_b [13] = '{32'h80000000, 32'd2, 32'd2, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd16, 32'hFFFFFFFE};
   md_op_t t16_op [8] = '{MULH, DIV, REM, DIVU, REM, DIV, MUL, MULHU};
   logic [31:0] t16_a [8] = '{32'h8000, 32'hFFF9, 32'hFFF9, 32'd5, 32'd5, 32'h8000, 32'h1234, 32'hFFFF};
   logic [31:0] t16_b [8] = '{32'h8000, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF, 32'h5678, 32'hFFFF};

   function automatic logic [31:0] md_ref(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input int w);
      longint mask, ua, ub, sa, sb, mn;
      logic [63:0] pu;
      mask = (longint'(1) << w) - 1;
      ua = longint'(a) & mask;
      ub = longint'(b) & mask;
      sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
      sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
      mn = -(longint'(1) << (w-1));
      pu = ua * ub;
      case (op)
         MUL:    return 32'((sa * sb) & mask);
         MULH:   return 32'(((sa * sb) >>> w) & mask);
         MULHSU: return 32'(((sa * ub) >>> w) & mask);
         MULHU:  return 32'((pu >> w) & mask);
         DIV:    return ub == 0 ? 32'(mask) : (sa == mn && sb == -1) ? 32'(ua) : 32'((sa / sb) & mask);
         REM:    return ub == 0 ? 32'(ua) : (sa == mn && sb == -1) ? 32'd0 : 32'((sa % sb) & mask);
         DIVU:   return ub == 0 ? 32'(mask) : 32'(ua / ub);
         REMU:   return ub == 0 ? 32'(ua) : 32'(ua % ub);
         default: return 32'd0;
      endcase
   endfunction

   task automatic issue(input alu_op_t ao, input md_op_t mo, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] bt, input ctrl_transfer_t c);
      @(negedge clk);
      alu_op = ao; md_op = mo; op1 = a; op2 = b; pc = p; btgt = bt; ct_in = c;
      rf_in = '{we: 1'b1, rd: 5'd3}; vld_in = 1'b1;
      @(negedge clk);
      vld_in = 1'b0; md_op = MD_NONE; alu_op = ALU_ADD; ct_in = '0; rf_in = '0;
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      while (stall_o && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (v32 !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", v32); end
      n_checks++; if (d32 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", d32); end
      n_checks++; if ({s32, sq32, mb32, bv32, jv32} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {s32, sq32, mb32, bv32, jv32}); end
      n_checks++; if ({rf32, bt32, jt32} !== '0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {rf32, bt32, jt32}); end
      n_checks++; if ({v16, s16, sq16, mb16, bv16, jv16, rf16, d16, bt16, jt16} !== '0) begin
         n_fail++; $display("FAIL reset_x16: got %h want 0", {v16, s16, sq16, mb16, bv16, jv16, rf16, d16, bt16, jt16});
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_alu;
      alu_op_t ops [10] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRA, ALU_SRL, ALU_AND, ALU_OR, ALU_XOR};
      logic [31:0] as [10] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h80000000,
                               32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
      logic [31:0] bs [10] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd31, 32'd4, 32'd4, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
      logic [31:0] es [10] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h80000000, 32'hF8000000, 32'h08000000,
                               32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0};
      use16 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sb_q.push_back(es[i]);
         issue(ops[i], MD_NONE, as[i], bs[i], 32'h100, 32'h0, '0);
         exp_v = sb_q.pop_front();
         n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall %s: got %b want 0", ops[i].name(), stall_o); end
         n_checks++; if (vld_o !== 1'b1) begin n_fail++; $display("FAIL alu_vld %s: got %b want 1", ops[i].name(), vld_o); end
         n_checks++; if (dout !== exp_v) begin n_fail++; $display("FAIL alu_data %s: got %h want %h", ops[i].name(), dout, exp_v); end
      end
      n_checks++; if (rf32 !== 6'b1_00011) begin n_fail++; $display("FAIL rf_pkt: got %h want %h", rf32, 6'b1_00011); end
   endtask

   task automatic run_md_table(input int w);
      md_op_t op;
      logic [31:0] a, b, mask;
      bit spc;
      int n, exp_n, cnt;
      cnt = w == 16 ? 8 : 13;
      mask = w == 16 ? 32'hFFFF : 32'hFFFFFFFF;
      for (int i = 0; i < cnt; i++) begin
         op = w == 16 ? t16_op[i] : t32_op[i];
         a = w == 16 ? t16_a[i] : t32_a[i];
         b = w == 16 ? t16_b[i] : t32_b[i];
         spc = (op inside {DIV, DIVU, REM, REMU}) && ((b & mask) == 0 ||
               ((op inside {DIV, REM}) && (a & mask) == ((mask >> 1) + 1) && (b & mask) == mask));
         exp_n = spc ? 1 : w + 1;
         sb_q.push_back(md_ref(op, a, b, w));
         issue(ALU_ADD, op, a, b, 32'h0, 32'h0, '0);
         wait_stall(n);
         exp_v = sb_q.pop_front();
         n_checks++; if (n != exp_n) begin n_fail++; $display("FAIL md_stall w=%0d %s: got %0d want %0d", w, op.name(), n, exp_n); end
         n_checks++; if (vld_o !== 1'b1) begin n_fail++; $display("FAIL md_vld w=%0d %s: got %b want 1", w, op.name(), vld_o); end
         n_checks++; if (dout !== exp_v) begin n_fail++; $display("FAIL md_data w=%0d %s: got %h want %h", w, op.name(), dout, exp_v); end
         @(negedge clk);
         n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL md_vld_pulse w=%0d %s: got %b want 0", w, op.name(), vld_o); end
      end
   endtask

   task automatic test_hold_done;
      int n;
      use16 = 1'b0;
      sb_q.push_back(md_ref(DIVU, 32'd100, 32'd7, 32));
      issue(ALU_ADD, DIVU, 32'd100, 32'd7, 32'h0, 32'h0, '0);
      wait_stall(n);
      exp_v = sb_q.pop_front();
      stall_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (vld_o !== 1'b1 || dout !== exp_v) begin n_fail++; $display("FAIL hold_done[%0d]: got vld=%b data=%h want vld=1 data=%h", k, vld_o, dout, exp_v); end
         @(negedge clk);
      end
      stall_in = 1'b0;
      @(negedge clk);
      n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", vld_o); end
   endtask

   task automatic test_back_to_back;
      int n;
      use16 = 1'b0;
      sb_q.push_back(md_ref(MUL, 32'h12345678, 32'h00000100, 32));
      sb_q.push_back(md_ref(MULHU, 32'hDEADBEEF, 32'hCAFEF00D, 32));
      @(negedge clk);
      md_op = MUL; op1 = 32'h12345678; op2 = 32'h100; vld_in = 1'b1;
      @(negedge clk);
      md_op = MULHU; op1 = 32'hDEADBEEF; op2 = 32'hCAFEF00D;
      wait_stall(n);
      exp_v = sb_q.pop_front();
      n_checks++; if (n != 33 || dout !== exp_v) begin n_fail++; $display("FAIL b2b_first: got n=%0d data=%h want n=33 data=%h", n, dout, exp_v); end
      @(negedge clk);
      vld_in = 1'b0; md_op = MD_NONE;
      wait_stall(n);
      exp_v = sb_q.pop_front();
      n_checks++; if (n != 33 || vld_o !== 1'b1 || dout !== exp_v) begin n_fail++; $display("FAIL b2b_second: got n=%0d vld=%b data=%h want n=33 vld=1 data=%h", n, vld_o, dout, exp_v); end
   endtask

   task automatic test_squash;
      use16 = 1'b0;
      issue(ALU_ADD, MUL, 32'd3, 32'd5, 32'h0, 32'h0, '0);
      repeat (10) @(negedge clk);
      n_checks++; if (busy_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL squash_pre: got busy=%b stall=%b want 1 1", busy_o, stall_o); end
      squash_in = 1'b1;
      #1;
      n_checks++; if (sq32 !== 1'b1 || stall_o !== 1'b0 || vld_o !== 1'b0) begin n_fail++; $display("FAIL squash_now: got sq=%b stall=%b vld=%b want 1 0 0", sq32, stall_o, vld_o); end
      @(negedge clk);
      squash_in = 1'b0;
      #1;
      n_checks++; if ({stall_o, vld_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL squash_after: got %b want 000", {stall_o, vld_o, busy_o}); end
      sb_q.push_back(32'd42);
      issue(ALU_ADD, MD_NONE, 32'd20, 32'd22, 32'h0, 32'h0, '0);
      exp_v = sb_q.pop_front();
      n_checks++; if (vld_o !== 1'b1 || dout !== exp_v) begin n_fail++; $display("FAIL squash_next_add: got vld=%b data=%h want vld=1 data=%h", vld_o, dout, exp_v); end
   endtask

   task automatic test_branch;
      logic [5:0] cts [5] = '{6'b001_000, 6'b001_001, 6'b001_100, 6'b001_110, 6'b001_111};
      logic [31:0] as [5] = '{32'd3, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bs [5] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'd1};
      logic tk [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      use16 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         issue(ALU_SUB, MD_NONE, as[i], bs[i], 32'h300, 32'h400 + i, cts[i]);
         n_checks++; if (bv32 !== tk[i] || sq32 !== tk[i]) begin n_fail++; $display("FAIL branch[%0d]: got bv=%b sq=%b want %b", i, bv32, sq32, tk[i]); end
         n_checks++; if (bt32 !== 32'h400 + i) begin n_fail++; $display("FAIL branch_tgt[%0d]: got %h want %h", i, bt32, 32'h400 + i); end
      end
      issue(ALU_ADD, MD_NONE, 32'h1001, 32'h0, 32'h200, 32'h0, 6'b010_000);
      n_checks++; if (jv32 !== 1'b1 || jt32 !== 32'h1000) begin n_fail++; $display("FAIL jalr_tgt: got vld=%b tgt=%h want 1 00001000", jv32, jt32); end
      n_checks++; if (d32 !== 32'h204 || sq32 !== 1'b1) begin n_fail++; $display("FAIL jalr_link: got data=%h sq=%b want 00000204 1", d32, sq32); end
   endtask

   task automatic test_reset_busy;
      use16 = 1'b0;
      issue(ALU_ADD, MUL, 32'd7, 32'd9, 32'h0, 32'h0, '0);
      repeat (5) @(negedge clk);
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b want 1", busy_o); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({busy_o, vld_o, stall_o} !== 3'b000 || dout !== 32'h0) begin n_fail++; $display("FAIL rst_busy: got flags=%b data=%h want 000 0", {busy_o, vld_o, stall_o}, dout); end
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      run_md_table(32);
      test_hold_done();
      test_back_to_back();
      test_squash();
      test_branch();
      test_reset_busy();
      use16 = 1'b1;
      run_md_table(16);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/x_stage_md.md
# x_stage_md

Parametrised execute stage with integrated RV M-extension unit. Registers the D→X pipeline packet, and resolves jalr and conditional branches. It computes ALU results through the existing `alu`. Multiply/divide ops run in an iterative shift-add/restoring unit that holds the pipeline with a self-generated stall. Sits between D and M stages; drops in where the single-cycle execute stage sits today.

## Interface
- `XLEN`, 32: datapath width, even, ≥8.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `alu_op_nxt` input `$bits(alu_op_t)`: ALU op from D.
- `md_op_nxt` input `$bits(md_op_t)`: M-ext op; `MD_NONE` = ALU instruction.
- `rf_ctrl_pkt_in` / `rf_ctrl_pkt_out` input/output `$bits(rf_ctrl_t)`: writeback control, registered.
- `ctrl_transfer_pkt_in` input `$bits(ctrl_transfer_t)`: is_jal/is_jalr/is_branch/branch_fn.
- `op1_nxt`, `op2_nxt`, `pc_nxt`, `branch_tgt_in` input XLEN: operands, PC, precomputed branch target.
- `data_out` output XLEN: ALU result, pc+4 for jal/jalr, or M-ext result.
- `branch_tgt` output XLEN: registered target. `branch_vld` output 1: taken branch.
- `jalr_tgt` output XLEN: ALU sum with bit0 cleared. `jalr_vld` output 1.
- `vld_in` input 1, `vld` output 1: instruction valid.
- `stall_in` input 1, `stall` output 1: downstream stall in; `stall_in | gen_stall` out.
- `squash_in` input 1, `squash` output 1: downstream squash in; `squash_in | jalr_vld | branch_vld` out.
- `md_busy` output 1: M-ext unit iterating (perf counter hook).

## Operation
- Pipeline regs (vld, ops, pc, alu_op, md_op, ctrl pkt, rf pkt, branch_tgt) load when `!stall`; reset to 0.
- Branch compare: branch_fn[2:1] selects eq/—/lt/ltu; branch_fn[0] inverts. `branch_vld = vld & is_branch & taken`. `jalr_vld = vld & is_jalr`.
- M-ext FSM states IDLE, BUSY, DONE. An instruction is an M-op when `vld_raw & md_op≠MD_NONE`.
  - IDLE + M-op, no squash_in → BUSY. Load |op1|, |op2| per signedness, record result sign, count = XLEN−1.
  - BUSY: one bit per cycle (multiply: shift-add into 2·XLEN accumulator; divide: restoring). count==0 → DONE.
  - DONE: hold result; → IDLE when `!stall_in` (register advances).
  - Any state + squash_in → IDLE next cycle; partial result discarded.
- `gen_stall = M-op & state≠DONE & !squash_in`. `vld = vld_raw & !gen_stall & !squash_in`.
- Results: MUL low XLEN; MULH/MULHSU/MULHU high XLEN of 2·XLEN product with sign fixup (two's complement of full product when signs differ).
- DIV/DIVU/REM/REMU: quotient/remainder. Sign of quotient = sign1^sign2; sign of remainder = dividend's.
- Divide by zero: skips BUSY, goes IDLE→DONE. Quotient = all ones; remainder = op1.
- Signed overflow (op1 = 1<<(XLEN−1), op2 = −1): IDLE→DONE. Quotient = op1, remainder = 0.
- All arithmetic modulo 2^XLEN except the internal 2·XLEN product.

## Timing
- ALU/branch/jump ops: result combinational from X registers, 0 extra cycles.
- Normal M-op: stall high for XLEN+1 cycles (arrival cycle + XLEN BUSY cycles). `vld`, result valid in cycle XLEN+2 (DONE).
- Div-by-zero/overflow: stall 1 cycle, result in cycle 2.
- stall_in held in DONE: result and vld stable; no recompute.
- Reset mid-BUSY: FSM IDLE, all outputs 0 immediately (async).
- M-op back-to-back: the second starts in IDLE the cycle after the first leaves DONE.

## Structure
- `core_types_pkg`: add `md_op_t` enum (MD_NONE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and `md_state_t`. Reuse `alu_op_t`, `rf_ctrl_t`, `ctrl_transfer_t`.
- Sub-module `muldiv_seq #(XLEN)`: FSM, counter, accumulator, sign fixup. Ports: start, kill, hold, op, a, b, busy, done, result.
- Reuse `alu`, `dl_reg_en_rst`, `dl_mux2`, `dl_mux4`.

## Test plan
- ADD 5+7, XLEN=32 → data_out=12, vld same cycle, stall=0.
- MULH 0x80000000×0x80000000 → stall 33 cycles, then data_out=0x40000000, vld=1 for one cycle.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF, after 33-cycle stall.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. All after a 1-cycle stall.
- squash_in at BUSY cycle 10 → next cycle stall=0, vld=0, md_busy=0. Following ADD completes normally.
- BEQ 3,3 with vld → branch_vld=1, squash=1. JALR op1=0x1001, op2=0 → jalr_tgt=0x1000, data_out=pc+4. XLEN=16 rerun of the MUL/DIV cases → 17-cycle stall.
